y86_alu: RTL and testbench

Integer ALU for the Y86 execute stage. It computes the 32-bit result of one of four operations (add, subtract, AND, XOR) on two operands supplied by the execute stage. It also maintains the architectural condition-code register (ZF, SF, OF) that conditional jumps and moves read. The result path is purely combinational, so the execute stage can capture `valE <= result` in the same cycle it selects the operands.

---
 rtl/y86_alu.sv | 75 +++++++
 tb/tb_y86_alu.sv | 139 +++++++++++++
 2 files changed

// File: rtl/y86_alu.sv
// Y86 execute-stage ALU: combinational add/sub/and/xor result plus the
// architectural ZF/SF/OF condition-code register.
module y86_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       op,
  input  logic             set_cc,
  output logic [WIDTH-1:0] result,
  output logic             ZF,
  output logic             SF,
  output logic             OF,
  output logic             op_err
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_result;
  logic             w_op_err;
  logic             w_zf_n;
  logic             w_sf_n;
  logic             w_of_n;

  // Operation select; undefined function codes force a zero result.
  always_comb begin
    w_result = {WIDTH{1'b0}};
    w_op_err = 1'b0;
    case (op)
      4'd0:    w_result = op1 + op2;
      4'd1:    w_result = op1 - op2;
      4'd2:    w_result = op1 & op2;
      4'd3:    w_result = op1 ^ op2;
      default: begin
        w_result = {WIDTH{1'b0}};
        w_op_err = 1'b1;
      end
    endcase
  end

  // Next condition codes; overflow only exists for the arithmetic ops.
  always_comb begin
    w_zf_n = (w_result == {WIDTH{1'b0}});
    w_sf_n = w_result[MSB];
    w_of_n = 1'b0;
    case (op)
      4'd0:    w_of_n = (op1[MSB] == op2[MSB]) && (w_result[MSB] != op1[MSB]);
      4'd1:    w_of_n = (op1[MSB] != op2[MSB]) && (w_result[MSB] != op1[MSB]);
      default: w_of_n = 1'b0;
    endcase
  end

  assign result = w_result;
  assign op_err = w_op_err;

  // Condition-code register; reset wins over set_cc, bad ops never load.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ZF <= 1'b1;
      SF <= 1'b0;
      OF <= 1'b0;
    end else if (set_cc && !w_op_err) begin
      ZF <= w_zf_n;
      SF <= w_sf_n;
      OF <= w_of_n;
    end else begin
      ZF <= ZF;
      SF <= SF;
      OF <= OF;
    end
  end

endmodule

// File: tb/tb_y86_alu.sv
// Scoreboard bench for y86_alu: directed corner vectors then random traffic,
// checked against an arithmetic reference model.
module tb_y86_alu;

  logic        clock;
  logic        reset_n;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  op;
  logic        set_cc;
  logic [31:0] result;
  logic        ZF;
  logic        SF;
  logic        OF;
  logic        op_err;

  y86_alu #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .op1(op1), .op2(op2), .op(op),
    .set_cc(set_cc), .result(result), .ZF(ZF), .SF(SF), .OF(OF), .op_err(op_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic        zf;
    logic        sf;
    logic        of;
    bit          fk;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference flag state
  logic m_zf, m_sf, m_of;
  bit   m_fk = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: compares whatever the ALU presents against the oldest expectation
  initial begin
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check({e.nm, ".result"}, result, e.res);
        check({e.nm, ".op_err"}, {31'd0, op_err}, {31'd0, e.err});
        if (e.fk) begin
          check({e.nm, ".ZF"}, {31'd0, ZF}, {31'd0, e.zf});
          check({e.nm, ".SF"}, {31'd0, SF}, {31'd0, e.sf});
          check({e.nm, ".OF"}, {31'd0, OF}, {31'd0, e.of});
        end
      end
    end
  end

  task automatic drive(input string nm, input logic rst_n, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b, input logic cc);
    exp_t        e;
    logic [31:0] r;
    logic        err, ovf;
    longint      sa, sb, s;
    @(posedge clock);
    #1;
    reset_n = rst_n; op = o; op1 = a; op2 = b; set_cc = cc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    err = 1'b0;
    ovf = 1'b0;
    case (o)
      4'd0: begin r = a + b; s = sa + sb; ovf = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000); end
      4'd1: begin r = a - b; s = sa - sb; ovf = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000); end
      4'd2: r = a & b;
      4'd3: r = a ^ b;
      default: begin r = 32'd0; err = 1'b1; end
    endcase
    e.res = r; e.err = err; e.zf = m_zf; e.sf = m_sf; e.of = m_of; e.fk = m_fk; e.nm = nm;
    q.push_back(e);
    if (!rst_n) begin
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_fk = 1'b1;
    end else if (cc && !err) begin
      m_zf = (r == 32'd0); m_sf = ($signed(r) < 0); m_of = ovf;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h7FFFFFFF;
      1: pick = 32'h80000000;
      2: pick = 32'hFFFFFFFF;
      3: pick = 32'd0;
      default: pick = $urandom();
    endcase
  endfunction

  initial begin
    reset_n = 1'b1; op = 4'd0; op1 = 32'd0; op2 = 32'd0; set_cc = 1'b0;
    drive("rst",      1'b0, 4'd0, 32'd5, 32'd0, 1'b1);
    drive("rst_rel",  1'b1, 4'd0, 32'd5, 32'd0, 1'b1);
    drive("add_ovf",  1'b1, 4'd0, 32'h7FFFFFFF, 32'd1, 1'b1);
    drive("sub_zero", 1'b1, 4'd1, 32'd7, 32'd7, 1'b1);
    drive("sub_neg",  1'b1, 4'd1, 32'd3, 32'd5, 1'b1);
    drive("sub_ovf",  1'b1, 4'd1, 32'h80000000, 32'd1, 1'b1);
    drive("and_zero", 1'b1, 4'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1);
    drive("xor_ones", 1'b1, 4'd3, 32'hFFFF0000, 32'h0000FFFF, 1'b1);
    drive("set_zf",   1'b1, 4'd1, 32'd9, 32'd9, 1'b1);
    drive("addr_add", 1'b1, 4'd0, 32'h100, 32'hFFFFFFFC, 1'b0);
    drive("bad_op",   1'b1, 4'd5, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    drive("bad_op15", 1'b1, 4'd15, 32'hFFFFFFFF, 32'h1, 1'b1);
    drive("mid_rst",  1'b0, 4'd3, 32'h80000000, 32'd0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] o;
      o = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      drive("rand", ($urandom_range(0, 39) != 0), o, pick(), pick(), 1'($urandom_range(0, 1)));
    end
    drive("tail", 1'b1, 4'd2, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
